// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: shared constants for the RV32 R/I-type ALU encoder.
//   - base opcodes for register and immediate ALU instructions
//   - 4-bit alu_op code, identical to the control decoder's encoding
//   - funct3 / funct7 field constants
package inst_encoder_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 for the plain variant and for the sub/sra variant
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/inst_encoder_fifo.sv
// inst_fifo: synchronous DEPTH x 32 FIFO with occupancy count.
//   clk, rstn      clock, asynchronous active-low reset
//   push, wdata    write request and data (ignored when full)
//   pop            read request (ignored when empty)
//   rdata          head word, reads 0 while empty
//   count          occupancy, full, empty
module inst_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [31:0]                wdata,
    input  logic                       pop,
    output logic [31:0]                rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Storage is not reset; masking keeps the head at 0 whenever nothing is held.
    assign rdata   = empty ? 32'h0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: builds RV32 R-type / I-type ALU instruction words from an
// alu_op code plus register/immediate fields, buffers them in a FIFO and
// streams them out with sequential word addresses.
//   in_valid/in_ready     request handshake (illegal requests accepted, dropped)
//   in_alu_op, in_use_imm, in_rd, in_rs1, in_rs2, in_imm   request fields
//   out_valid/out_ready   word handshake; out_inst head word, out_addr its address
//   count                 FIFO occupancy
//   err, err_cnt          sticky illegal flag, saturating illegal count
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_alu_op,
    input  logic                       in_use_imm,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [4:0]                 in_rs2,
    input  logic [11:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_addr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err,
    output logic [7:0]                 err_cnt
);
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_shift;
    logic        illegal;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    always_comb begin
        funct3   = F3_ADD_SUB;
        funct7   = F7_BASE;
        is_shift = 1'b0;
        illegal  = 1'b0;
        case (in_alu_op)
            ALU_ADD:  funct3 = F3_ADD_SUB;
            ALU_SUB:  begin
                funct7  = F7_ALT;
                illegal = in_use_imm;   // there is no subi
            end
            ALU_AND:  funct3 = F3_AND;
            ALU_OR:   funct3 = F3_OR;
            ALU_XOR:  funct3 = F3_XOR;
            ALU_SLT:  funct3 = F3_SLT;
            ALU_SLTU: funct3 = F3_SLTU;
            ALU_SLL:  begin
                funct3   = F3_SLL;
                is_shift = 1'b1;
            end
            ALU_SRL:  begin
                funct3   = F3_SRL_SRA;
                is_shift = 1'b1;
            end
            ALU_SRA:  begin
                funct3   = F3_SRL_SRA;
                funct7   = F7_ALT;
                is_shift = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase

        if (!in_use_imm)
            word = {funct7, in_rs2, in_rs1, funct3, in_rd, OP_R};
        else if (is_shift)
            // immediate shifts carry funct7 in imm[11:5]; caller's upper bits are discarded
            word = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OP_I};
        else
            word = {in_imm, in_rs1, funct3, in_rd, OP_I};
    end

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign accept    = in_valid & in_ready;
    assign push      = accept & ~illegal;
    assign pop       = out_valid & out_ready;

    inst_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (out_inst),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_addr <= BASE_ADDR;
            err      <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            if (pop) out_addr <= out_addr + 32'd4;
            if (accept && illegal) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          CW    = $clog2(DEPTH) + 1;
    // funct3 indexed by alu_op code 0..9
    localparam logic [2:0] F3_TAB [10] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd2, 3'd3, 3'd1, 3'd5, 3'd5};

    logic          clk, rstn;
    logic          in_valid, in_ready, in_use_imm, out_valid, out_ready, err;
    logic [3:0]    in_alu_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [11:0]   in_imm;
    logic [31:0]   out_inst, out_addr;
    logic [CW-1:0] count;
    logic [7:0]    err_cnt;

    inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_op(in_alu_op), .in_use_imm(in_use_imm),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_addr(out_addr),
        .count(count), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] q[$];
    logic [31:0] m_addr;
    bit          m_err;
    int          m_ecnt;
    int          checks = 0;
    int          errors = 0;

    function automatic bit ref_legal(logic [3:0] op, logic ui);
        return (op <= 4'd9) && !(op == 4'd1 && ui);
    endfunction

    function automatic logic [31:0] ref_word(logic [3:0] op, logic ui, logic [4:0] rd,
                                             logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = F3_TAB[int'(op)];
        f7 = (op == 4'd1 || op == 4'd9) ? 7'h20 : 7'h00;
        if (!ui) return {f7, rs2, rs1, f3, rd, 7'b0110011};
        if (op >= 4'd7) return {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = BASE;
        m_err  = 0;
        m_ecnt = 0;
    endtask

    task automatic model_edge();
        bit pop_now, acc;
        pop_now = (q.size() != 0) && out_ready;
        acc     = in_valid && (q.size() < DEPTH);
        if (pop_now) begin
            void'(q.pop_front());
            m_addr = m_addr + 32'd4;
        end
        if (acc) begin
            if (ref_legal(in_alu_op, in_use_imm))
                q.push_back(ref_word(in_alu_op, in_use_imm, in_rd, in_rs1, in_rs2, in_imm));
            else begin
                m_err = 1;
                if (m_ecnt < 255) m_ecnt++;
            end
        end
    endtask

    task automatic compare();
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("out_addr", out_addr, m_addr);
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_ecnt));
        if (q.size() != 0) chk("out_inst", out_inst, q[0]);
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge clk);
        if (rstn) model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic req(input logic [3:0] op, input logic ui, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        in_valid = 1'b1; in_alu_op = op; in_use_imm = ui;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        compare();
        cycle();
        rstn = 1'b1;   // released on a falling edge
    endtask

    initial begin
        rstn = 1'b0; in_valid = 0; out_ready = 0; in_alu_op = 0; in_use_imm = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        cycle();
        rstn = 1'b1;

        // add x3,x1,x2
        req(4'd0, 0, 5'd3, 5'd1, 5'd2, 12'd0);
        cycle();
        in_valid = 0;
        chk("add_word", out_inst, 32'h002081B3);
        chk("add_addr", out_addr, 32'h0);
        out_ready = 1;
        cycle();

        // sub then addi with out_ready=1, fresh addresses
        do_reset();
        out_ready = 1;
        req(4'd1, 0, 5'd5, 5'd6, 5'd7, 12'd0);
        cycle();
        chk("sub_word", out_inst, 32'h407302B3);
        chk("sub_addr", out_addr, 32'h0);
        req(4'd0, 1, 5'd1, 5'd0, 5'd0, 12'hFFF);
        cycle();
        chk("addi_word", out_inst, 32'hFFF00093);
        chk("addi_addr", out_addr, 32'h4);
        in_valid = 0;
        cycle();

        // srai with junk in imm[11:5]
        out_ready = 0;
        req(4'd9, 1, 5'd2, 5'd2, 5'd0, 12'h7E3);
        cycle();
        in_valid = 0;
        chk("srai_word", out_inst, 32'h40315113);
        out_ready = 1;
        cycle();

        // illegal requests
        do_reset();
        req(4'b1011, 0, 5'd1, 5'd1, 5'd1, 12'd0);
        cycle();
        req(4'd1, 1, 5'd1, 5'd1, 5'd1, 12'd0);
        cycle();
        in_valid = 0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_err_cnt", 32'(err_cnt), 32'd2);
        chk("ill_count", 32'(count), 32'd0);

        // fill with DEPTH+1 requests, backpressured
        do_reset();
        out_ready = 0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            req(4'd0, 0, 5'(i), 5'd1, 5'd2, 12'd0);
            cycle();
        end
        in_valid = 0;
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", out_inst, 32'h002080B3);
        cycle();
        chk("full_head_stable", out_inst, 32'h002080B3);
        out_ready = 1;
        cycle();
        chk("after_pop_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) cycle();

        // mid-stream reset with three words held; request pending across release
        out_ready = 0;
        req(4'hF, 0, 5'd0, 5'd0, 5'd0, 12'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            req(4'd4, 1, 5'(i + 8), 5'd3, 5'd0, 12'(i * 77));
            cycle();
        end
        in_valid = 0;
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_addr", out_addr, BASE);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        req(4'd3, 0, 5'd9, 5'd10, 5'd11, 12'd0);
        rstn = 1'b1;
        cycle();
        in_valid = 0;
        chk("post_rst_word", out_inst, 32'h00B564B3);

        // err_cnt saturation
        out_ready = 1;
        for (int i = 0; i < 260; i++) begin
            req(4'(10 + (i % 6)), 1'(i % 2), 5'd0, 5'd0, 5'd0, 12'd0);
            cycle();
        end
        in_valid = 0;
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            req(op, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < (i < 1500 ? 7 : 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
